// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, R-type func
// codes, ALU control codes, controller states and the ALU mode selector.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALUC_AND = 4'b0000;
   localparam logic [3:0] ALUC_OR  = 4'b0001;
   localparam logic [3:0] ALUC_ADD = 4'b0010;
   localparam logic [3:0] ALUC_SUB = 4'b0110;
   localparam logic [3:0] ALUC_SLT = 4'b0111;
   localparam logic [3:0] ALUC_SLL = 4'b1000;
   localparam logic [3:0] ALUC_SRL = 4'b1001;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_R_EXEC    = 4'd2,
      S_R_WB      = 4'd3,
      S_MEM_ADDR  = 4'd4,
      S_MEM_READ  = 4'd5,
      S_MEM_WB    = 4'd6,
      S_MEM_WRITE = 4'd7,
      S_BRANCH    = 4'd8,
      S_I_EXEC    = 4'd9,
      S_I_WB      = 4'd10,
      S_ILLEGAL   = 4'd11
   } state_t;

   typedef enum logic [2:0] {
      AM_ADD  = 3'd0,
      AM_SUB  = 3'd1,
      AM_FUNC = 3'd2,
      AM_ANDI = 3'd3,
      AM_ORI  = 3'd4
   } alu_mode_t;

   // True for the R-type func codes the core implements.
   function automatic logic is_rtype_func(input logic [5:0] f);
      case (f)
         FN_ADD, FN_SUB, FN_SLL, FN_SRL, FN_AND, FN_OR, FN_SLT: return 1'b1;
         default:                                               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_control_decoder.sv
// Maps the controller's ALU mode (and func for R-type) to the 4-bit ALU
// control code.
module alu_control_decoder
   import mips_ctrl_pkg::*;
(
   input  alu_mode_t   i_alu_mode,
   input  logic [5:0]  i_func,
   output logic [3:0]  o_aluc
);

   // Pure lookup; unknown func never reaches here because DECODE traps it.
   always_comb begin
      o_aluc = ALUC_ADD;
      case (i_alu_mode)
         AM_ADD:  o_aluc = ALUC_ADD;
         AM_SUB:  o_aluc = ALUC_SUB;
         AM_ANDI: o_aluc = ALUC_AND;
         AM_ORI:  o_aluc = ALUC_OR;
         AM_FUNC: begin
            case (i_func)
               FN_ADD:  o_aluc = ALUC_ADD;
               FN_SUB:  o_aluc = ALUC_SUB;
               FN_SLL:  o_aluc = ALUC_SLL;
               FN_SRL:  o_aluc = ALUC_SRL;
               FN_AND:  o_aluc = ALUC_AND;
               FN_OR:   o_aluc = ALUC_OR;
               FN_SLT:  o_aluc = ALUC_SLT;
               default: o_aluc = ALUC_ADD;
            endcase
         end
         default: o_aluc = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller. State and the memory wait counter
// are registered; all strobes are decoded combinationally from the current
// state (plus mem_ready for the "on ready" strobes) and forced low in reset.
// Memory handshake: a request (mem_read/mem_write) is held every cycle of a
// memory state; the access completes in the cycle mem_ready=1, and mem_ready
// is ignored in every other state.
module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [5:0]  func,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  pc_source,
   output logic [3:0]  aluc,
   output logic        illegal_op,
   output logic        mem_timeout,
   output logic [3:0]  state
);

   localparam logic [3:0] WAIT_SAT      = 4'(MEM_WAIT_MAX);
   localparam logic [3:0] WAIT_PULSE_AT = 4'(MEM_WAIT_MAX - 1);

   state_t      r_state;
   logic [3:0]  r_wait;
   logic        w_waiting;
   logic        w_alu_en;
   alu_mode_t   w_alu_mode;
   logic [3:0]  w_aluc;
   logic        w_unused_zero;

   // zero is gated with pc_write_cond in the datapath, not here.
   assign w_unused_zero = zero;

   assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                       (r_state == S_MEM_WRITE)) && !mem_ready;

   // The pulse lands in the MEM_WAIT_MAX-th consecutive wait cycle.
   assign mem_timeout = !rst && w_waiting && (r_wait == WAIT_PULSE_AT);
   assign state       = r_state;

   // State sequencing and saturating memory wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_wait  <= 4'd0;
      end else begin
         if (w_waiting) begin
            if (r_wait != WAIT_SAT) r_wait <= r_wait + 4'd1;
         end else begin
            r_wait <= 4'd0;
         end
         case (r_state)
            S_FETCH:     if (mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_RTYPE:                r_state <= is_rtype_func(func) ? S_R_EXEC : S_ILLEGAL;
                  OP_LW, OP_LH, OP_SW:     r_state <= S_MEM_ADDR;
                  OP_BEQ:                  r_state <= S_BRANCH;
                  OP_ADDI, OP_ANDI, OP_ORI: r_state <= S_I_EXEC;
                  default:                 r_state <= S_ILLEGAL;
               endcase
            end
            S_R_EXEC:    r_state <= S_R_WB;
            S_MEM_ADDR:  r_state <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
            S_I_EXEC:    r_state <= S_I_WB;
            default:     r_state <= S_FETCH;
         endcase
      end
   end

   alu_control_decoder u_alu_dec (
      .i_alu_mode (w_alu_mode),
      .i_func     (func),
      .o_aluc     (w_aluc)
   );

   assign aluc = w_alu_en ? w_aluc : ALUC_AND;

   // Per-state strobe decode; everything held low while rst is high.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      w_alu_en      = 1'b0;
      w_alu_mode    = AM_ADD;
      if (!rst) begin
         case (r_state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               w_alu_en  = 1'b1;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
               w_alu_en  = 1'b1;
            end
            S_R_EXEC: begin
               alu_src_a  = 1'b1;
               w_alu_en   = 1'b1;
               w_alu_mode = AM_FUNC;
            end
            S_R_WB: begin
               reg_dst   = 1'b1;
               reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               w_alu_en  = 1'b1;
            end
            S_MEM_READ: begin
               iord     = 1'b1;
               mem_read = 1'b1;
            end
            S_MEM_WB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
               iord      = 1'b1;
               mem_write = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               w_alu_en      = 1'b1;
               w_alu_mode    = AM_SUB;
            end
            S_I_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               w_alu_en  = 1'b1;
               case (opcode)
                  OP_ANDI: w_alu_mode = AM_ANDI;
                  OP_ORI:  w_alu_mode = AM_ORI;
                  default: w_alu_mode = AM_ADD;
               endcase
            end
            S_I_WB:    reg_write  = 1'b1;
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed per-cycle vectors push the
// hand-derived control word into a queue; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;
   import mips_ctrl_pkg::*;

   localparam int W = 24;

   // strobe field order: pc_write, pc_write_cond, iord, mem_read, mem_write,
   // ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a
   localparam logic [9:0] M_PCW  = 10'b1000000000;
   localparam logic [9:0] M_PCWC = 10'b0100000000;
   localparam logic [9:0] M_IORD = 10'b0010000000;
   localparam logic [9:0] M_MRD  = 10'b0001000000;
   localparam logic [9:0] M_MWR  = 10'b0000100000;
   localparam logic [9:0] M_IRW  = 10'b0000010000;
   localparam logic [9:0] M_RDST = 10'b0000001000;
   localparam logic [9:0] M_M2R  = 10'b0000000100;
   localparam logic [9:0] M_RW   = 10'b0000000010;
   localparam logic [9:0] M_SRCA = 10'b0000000001;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [5:0] opcode = 6'd0;
   logic [5:0] func   = 6'd0;
   logic       zero   = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op, mem_timeout;
   logic [1:0] alu_src_b, pc_source;
   logic [3:0] aluc, state;

   multicycle_control_fsm #(.MEM_WAIT_MAX(15)) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .func          (func),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .pc_source     (pc_source),
      .aluc          (aluc),
      .illegal_op    (illegal_op),
      .mem_timeout   (mem_timeout),
      .state         (state)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           checks   = 0;
   int           failures = 0;

   function automatic logic [W-1:0] ev(state_t st, logic [9:0] sb, logic [1:0] srcb,
                                       logic [1:0] pcs, logic [3:0] al, logic ill, logic to);
      return {st, sb, srcb, pcs, al, ill, to};
   endfunction

   logic [W-1:0] e_zero, e_fetch_w, e_fetch_r, e_fetch_to, e_decode, e_r_wb, e_mem_addr;
   logic [W-1:0] e_mem_read, e_mem_wb, e_mem_write, e_branch, e_i_wb, e_illegal;

   // monitor: every cycle the DUT presents a control word; compare at negedge
   initial begin
      logic [W-1:0] got, want;
      string        t;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            t    = tag_q.pop_front();
            got  = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
                    aluc, illegal_op, mem_timeout};
            checks++;
            if (got !== want) begin
               failures++;
               $display("FAIL %s: got state=%0d ctl=%h want state=%0d ctl=%h",
                        t, got[W-1 -: 4], got[W-5:0], want[W-1 -: 4], want[W-5:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic r, input logic rdy, input logic [W-1:0] e, input string t);
      @(posedge clk);
      #1;
      rst       = r;
      mem_ready = rdy;
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      func   = fn;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      e_zero      = '0;
      e_fetch_w   = ev(S_FETCH, M_MRD, 2'b01, 2'b00, 4'b0010, 1'b0, 1'b0);
      e_fetch_to  = ev(S_FETCH, M_MRD, 2'b01, 2'b00, 4'b0010, 1'b0, 1'b1);
      e_fetch_r   = ev(S_FETCH, M_MRD | M_IRW | M_PCW, 2'b01, 2'b00, 4'b0010, 1'b0, 1'b0);
      e_decode    = ev(S_DECODE, 10'd0, 2'b11, 2'b00, 4'b0010, 1'b0, 1'b0);
      e_r_wb      = ev(S_R_WB, M_RDST | M_RW, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
      e_mem_addr  = ev(S_MEM_ADDR, M_SRCA, 2'b10, 2'b00, 4'b0010, 1'b0, 1'b0);
      e_mem_read  = ev(S_MEM_READ, M_IORD | M_MRD, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
      e_mem_wb    = ev(S_MEM_WB, M_M2R | M_RW, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
      e_mem_write = ev(S_MEM_WRITE, M_IORD | M_MWR, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
      e_branch    = ev(S_BRANCH, M_SRCA | M_PCWC, 2'b00, 2'b01, 4'b0110, 1'b0, 1'b0);
      e_i_wb      = ev(S_I_WB, M_RW, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
      e_illegal   = ev(S_ILLEGAL, 10'd0, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0);

      // reset held: everything low, state FETCH
      step(1'b1, 1'b1, e_zero, "reset_hold");

      // add: 4 cycles, aluc ADD in R_EXEC, rd write in R_WB
      set_ir(6'b000000, 6'b100000);
      step(1'b0, 1'b1, e_fetch_r, "add_fetch");
      step(1'b0, 1'b1, e_decode, "add_decode");
      step(1'b0, 1'b1, ev(S_R_EXEC, M_SRCA, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0), "add_exec");
      step(1'b0, 1'b1, e_r_wb, "add_wb");

      // sub / slt / srl: check func-driven aluc
      set_ir(6'b000000, 6'b100010);
      step(1'b0, 1'b1, e_fetch_r, "sub_fetch");
      step(1'b0, 1'b1, e_decode, "sub_decode");
      step(1'b0, 1'b1, ev(S_R_EXEC, M_SRCA, 2'b00, 2'b00, 4'b0110, 1'b0, 1'b0), "sub_exec");
      step(1'b0, 1'b1, e_r_wb, "sub_wb");
      set_ir(6'b000000, 6'b101010);
      step(1'b0, 1'b1, e_fetch_r, "slt_fetch");
      step(1'b0, 1'b1, e_decode, "slt_decode");
      step(1'b0, 1'b1, ev(S_R_EXEC, M_SRCA, 2'b00, 2'b00, 4'b0111, 1'b0, 1'b0), "slt_exec");
      step(1'b0, 1'b1, e_r_wb, "slt_wb");
      set_ir(6'b000000, 6'b000010);
      step(1'b0, 1'b1, e_fetch_r, "srl_fetch");
      step(1'b0, 1'b1, e_decode, "srl_decode");
      step(1'b0, 1'b1, ev(S_R_EXEC, M_SRCA, 2'b00, 2'b00, 4'b1001, 1'b0, 1'b0), "srl_exec");
      step(1'b0, 1'b1, e_r_wb, "srl_wb");

      // lw with 3 wait cycles in MEM_READ: 8 cycles
      set_ir(6'b100011, 6'b000000);
      step(1'b0, 1'b1, e_fetch_r, "lw_fetch");
      step(1'b0, 1'b1, e_decode, "lw_decode");
      step(1'b0, 1'b1, e_mem_addr, "lw_addr");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, e_mem_read, "lw_read_wait");
      step(1'b0, 1'b1, e_mem_read, "lw_read_ready");
      step(1'b0, 1'b1, e_mem_wb, "lw_wb");

      // beq with zero=1: 3 cycles
      set_ir(6'b000100, 6'b000000);
      zero = 1'b1;
      step(1'b0, 1'b1, e_fetch_r, "beq_fetch");
      step(1'b0, 1'b1, e_decode, "beq_decode");
      step(1'b0, 1'b1, e_branch, "beq_branch");

      // 20 not-ready FETCH cycles: timeout only in the 15th, then ready
      zero = 1'b0;
      for (int i = 1; i <= 20; i++)
         step(1'b0, 1'b0, (i == 15) ? e_fetch_to : e_fetch_w, "fetch_wait");
      set_ir(6'b101011, 6'b000000);
      step(1'b0, 1'b1, e_fetch_r, "sw_fetch");
      step(1'b0, 1'b1, e_decode, "sw_decode");
      step(1'b0, 1'b1, e_mem_addr, "sw_addr");
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, e_mem_write, "sw_write_wait");
      step(1'b0, 1'b1, e_mem_write, "sw_write_ready");

      // unsupported opcode: one-cycle illegal_op, no writes
      set_ir(6'b111111, 6'b000000);
      step(1'b0, 1'b1, e_fetch_r, "bad_fetch");
      step(1'b0, 1'b1, e_decode, "bad_decode");
      step(1'b0, 1'b1, e_illegal, "bad_illegal");

      // R-type with unknown func is also illegal
      set_ir(6'b000000, 6'b111111);
      step(1'b0, 1'b1, e_fetch_r, "badfn_fetch");
      step(1'b0, 1'b1, e_decode, "badfn_decode");
      step(1'b0, 1'b1, e_illegal, "badfn_illegal");

      // ori: aluc OR in I_EXEC
      set_ir(6'b001101, 6'b000000);
      step(1'b0, 1'b1, e_fetch_r, "ori_fetch");
      step(1'b0, 1'b1, e_decode, "ori_decode");
      step(1'b0, 1'b1, ev(S_I_EXEC, M_SRCA, 2'b10, 2'b00, 4'b0001, 1'b0, 1'b0), "ori_exec");
      step(1'b0, 1'b1, e_i_wb, "ori_wb");

      // lh reaching MEM_READ, then async reset mid-wait
      set_ir(6'b100001, 6'b000000);
      step(1'b0, 1'b1, e_fetch_r, "lh_fetch");
      step(1'b0, 1'b1, e_decode, "lh_decode");
      step(1'b0, 1'b1, e_mem_addr, "lh_addr");
      step(1'b0, 1'b0, e_mem_read, "lh_read_wait");
      step(1'b1, 1'b0, e_zero, "rst_mid_read");
      step(1'b1, 1'b1, e_zero, "rst_hold");
      step(1'b0, 1'b0, e_fetch_w, "post_rst_fetch");

      // andi after reset: aluc AND in I_EXEC
      set_ir(6'b001100, 6'b000000);
      step(1'b0, 1'b1, e_fetch_r, "andi_fetch");
      step(1'b0, 1'b1, e_decode, "andi_decode");
      step(1'b0, 1'b1, ev(S_I_EXEC, M_SRCA, 2'b10, 2'b00, 4'b0000, 1'b0, 1'b0), "andi_exec");
      step(1'b0, 1'b1, e_i_wb, "andi_wb");
      step(1'b0, 1'b0, e_fetch_w, "end_fetch");

      // drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 4; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequencing controller for the multi-cycle build of the MIPS core. Instruction fetch, register read, ALU execute, memory access and write-back share one ALU and one unified memory port, and this block drives them over successive cycles. It decodes the instruction register's opcode/func fields into per-state control strobes and the 4-bit ALU control. It stalls on a memory-ready handshake.

Parameters:
MEM_WAIT_MAX, 15, number of consecutive not-ready memory cycles before mem_timeout pulses; the FSM keeps waiting after the pulse.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26]; valid from DECODE onward
func  input  6  IR[5:0]
zero  input  1  ALU zero flag; sampled in BRANCH
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero
iord  output  1  0 = memory address from PC, 1 = from ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load the instruction register
reg_dst  output  1  1 = rd, 0 = rt
mem_to_reg  output  1  1 = write-back from MDR
reg_write  output  1  register-file write
alu_src_a  output  1  0 = PC, 1 = A register
alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sext imm << 2
pc_source  output  2  00 = ALU result, 01 = ALUOut
aluc  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRL
illegal_op  output  1  one-cycle pulse on an unsupported opcode/func
mem_timeout  output  1  one-cycle pulse when the wait count reaches MEM_WAIT_MAX
state  output  4  current state, for debug

Behaviour:
- Reset: while rst=1, state=FETCH, the wait counter is 0, and every output other than state is forced 0. The first FETCH cycle follows rst deassertion.
- Outputs are decoded combinationally from the state. Strobes marked "on ready" also require mem_ready=1.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluc=ADD.
  - On ready: ir_write=1, pc_write=1, pc_source=00, next state DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, aluc=ADD (branch target into ALUOut). Next state:
  - R_EXEC for opcode 000000 with func in {100000 add, 100010 sub, 000000 sll, 000010 srl, 100100 and, 100101 or, 101010 slt}.
  - MEM_ADDR for 100011 lw, 100001 lh, 101011 sw.
  - BRANCH for 000100 beq.
  - I_EXEC for 001000 addi, 001100 andi, 001101 ori.
  - ILLEGAL for anything else, including an unknown func.
- R_EXEC: alu_src_a=1, alu_src_b=00, aluc from func. Next R_WB.
- R_WB: reg_dst=1, reg_write=1, mem_to_reg=0. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluc=ADD. Next MEM_READ for lw/lh, MEM_WRITE for sw.
- MEM_READ: iord=1, mem_read=1. On ready go to MEM_WB, else hold.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH. lh byte selection and sign extension are done in the datapath, not here.
- MEM_WRITE: iord=1, mem_write=1. On ready go to FETCH, else hold.
- BRANCH: alu_src_a=1, alu_src_b=00, aluc=SUB, pc_write_cond=1, pc_source=01. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, aluc ADD/AND/OR for addi/andi/ori. Next I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH.
- ILLEGAL: illegal_op=1 for one cycle, no register or memory write. Next FETCH; the PC has already advanced past the bad instruction.
- Cycle counts with zero wait: R-type, I-type and sw take 4 cycles; lw/lh take 5; beq takes 3. Each memory wait cycle adds 1.
- Wait counter (4 bits): increments each cycle in FETCH, MEM_READ or MEM_WRITE while mem_ready=0, and clears otherwise.
  - mem_timeout pulses in the cycle the count equals MEM_WAIT_MAX.
  - The counter then saturates, with no further pulses until it clears.
- mem_ready=1 outside the memory states is ignored.
- opcode/func may change outside DECODE/EXEC with no effect; IR stability is the datapath's responsibility.
- Asserting rst mid-instruction aborts it immediately and asynchronously. A pending register or memory write never completes.
- Unused encodings of state go to FETCH on the next edge.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_LH, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI;
  - func constants;
  - ALUC_* codes;
  - the 4-bit state enum.
- The datapath and ALU also use this package.
- One sub-module, alu_control_decoder: a combinational map from the ALU mode (add / sub / func / andi / ori) and func to aluc. It is instantiated once.

Test Plan:
1. Reset: rst=1 mid-MEM_READ → state=FETCH, all strobes 0; after release, mem_read=1 and iord=0 in the next cycle.
2. add (opcode 000000, func 100000), mem_ready always 1 → states FETCH, DECODE, R_EXEC, R_WB. aluc=0010 in R_EXEC, reg_write=1 and reg_dst=1 in cycle 4, then FETCH.
3. lw (100011) with mem_ready low for 3 cycles in MEM_READ → 8 cycles total; reg_write=1 and mem_to_reg=1 in MEM_WB only.
4. beq (000100), zero=1 → 3 cycles; pc_write_cond=1, pc_source=01, aluc=0110 in BRANCH.
5. sw (101011) then opcode 111111 → mem_write=1 held until ready; the next instruction gives illegal_op=1 for exactly one cycle and never asserts reg_write.
6. mem_ready held 0 in FETCH for 20 cycles → mem_timeout pulses once, in the 15th wait cycle, and the FSM remains in FETCH until ready.
